// File: rtl/wb_led_sequencer_if.sv
// Write-only Wishbone bundle between the LED sequencer (master) and the LED controller (slave).
interface wb_led_sequencer_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat;
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;

    modport master (output adr, dat, we, sel, stb, cyc, input ack, err);
    modport slave  (input adr, dat, we, sel, stb, cyc, output ack, err);
endinterface

// File: rtl/wb_led_sequencer.sv
// Autonomous Wishbone master that blinks, chases or clears the LED controller
// on a programmable tick, with ack timeout and overrun reporting.
module wb_led_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int                    LED_WIDTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    PERIOD_WIDTH = 24,
    parameter int                    TIMEOUT      = 16,
    parameter logic [LED_WIDTH-1:0]  BLINK_MASK   = 4'hF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    wb_led_sequencer_if.master      wbm,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic                    overrun_o
);

    localparam int                  TO_WIDTH   = $clog2(TIMEOUT + 1);
    localparam logic [TO_WIDTH-1:0] TO_LAST    = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [1:0]          MODE_OFF   = 2'd0;
    localparam logic [1:0]          MODE_BLINK = 2'd1;
    localparam logic [1:0]          MODE_CHASE = 2'd2;
    localparam logic [1:0]          MODE_CLEAR = 2'd3;

    typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q;
    logic [1:0]              cur_mode_q, cur_mode_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    pending_q, pending_d;
    logic                    clear_done_q, clear_done_d;
    logic [LED_WIDTH-1:0]    pos_q, pos_d;
    logic [TO_WIDTH-1:0]     to_q, to_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    cyc_q, cyc_d;
    logic                    timeout_q, timeout_d;
    logic                    overrun_q, overrun_d;
    logic                    mode_chg;
    logic                    tick;
    logic                    finish;

    // Tick counter; >= keeps it wrapping promptly if period_i shrinks mid-count.
    always_comb begin
        mode_chg = (mode_i != mode_q);
        tick     = 1'b0;
        cnt_d    = '0;
        if (!mode_chg && (mode_i == MODE_BLINK || mode_i == MODE_CHASE)) begin
            if (cnt_q >= period_i) begin
                tick = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_mode_d   = cur_mode_q;
        pending_d    = pending_q;
        clear_done_d = clear_done_q;
        pos_d        = pos_q;
        to_d         = to_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        cyc_d        = cyc_q;
        timeout_d    = 1'b0;
        overrun_d    = tick & pending_q;
        finish       = 1'b0;

        if (tick) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (mode_i != MODE_OFF && !mode_chg && (pending_q || tick)) begin
                    pending_d  = 1'b0;
                    cyc_d      = 1'b1;
                    to_d       = '0;
                    cur_mode_d = mode_i;
                    state_d    = BUS;
                    unique case (mode_i)
                        MODE_BLINK: begin
                            adr_d = BASE_ADDR + ADDR_WIDTH'(4);
                            dat_d = DATA_WIDTH'(BLINK_MASK);
                        end
                        MODE_CHASE: begin
                            adr_d = BASE_ADDR;
                            dat_d = DATA_WIDTH'(pos_q);
                        end
                        default: begin
                            adr_d = BASE_ADDR + ADDR_WIDTH'(8);
                            dat_d = DATA_WIDTH'({LED_WIDTH{1'b1}});
                        end
                    endcase
                end
            end
            BUS: begin
                // Ack wins over a simultaneous err.
                if (wbm.ack) begin
                    cyc_d   = 1'b0;
                    finish  = 1'b1;
                    state_d = GAP;
                    if (cur_mode_q == MODE_CHASE) begin
                        pos_d = (pos_q << 1) | (pos_q >> (LED_WIDTH - 1));
                    end
                end else if (wbm.err || to_q == TO_LAST) begin
                    cyc_d     = 1'b0;
                    finish    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish && cur_mode_q == MODE_CLEAR && mode_i == MODE_CLEAR) begin
            clear_done_d = 1'b1;
        end

        // A mode change drops stale ticks; entering clear mode queues its single write.
        if (mode_chg) begin
            pending_d = (mode_i == MODE_CLEAR) && !clear_done_q;
            if (mode_q == MODE_CLEAR) begin
                clear_done_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= MODE_OFF;
            cur_mode_q   <= MODE_OFF;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            clear_done_q <= 1'b0;
            pos_q        <= LED_WIDTH'(1);
            to_q         <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            cyc_q        <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_i;
            cur_mode_q   <= cur_mode_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            clear_done_q <= clear_done_d;
            pos_q        <= pos_d;
            to_q         <= to_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            cyc_q        <= cyc_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign wbm.adr   = adr_q;
    assign wbm.dat   = dat_q;
    assign wbm.cyc   = cyc_q;
    assign wbm.stb   = cyc_q;
    assign wbm.we    = cyc_q;
    assign wbm.sel   = {SELECT_WIDTH{cyc_q}};
    assign busy_o    = (state_q == BUS);
    assign timeout_o = timeout_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_wb_led_sequencer.sv
// Directed bench for wb_led_sequencer against a behavioural LED controller slave
// with configurable ack latency, stall and error response.
module tb_wb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  modeIn = 2'd0;
    logic [23:0] periodIn = 24'd0;
    logic        busy_o, timeout_o, overrun_o;

    int compareCount  = 0;
    int mismatchCount = 0;
    int ackDelay = 1;
    int useErr   = 0;
    int waitCnt;
    int cycleNum = 0;
    int toCount  = 0;
    int ovCount  = 0;
    logic [3:0]  ledReg;
    logic [31:0] writeAdr[$];
    logic [31:0] writeDat[$];
    logic [3:0]  ledLog[$];
    int          ackCycle[$];

    wb_led_sequencer_if wbm ();

    wb_led_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .mode_i    (modeIn),
        .period_i  (periodIn),
        .wbm       (wbm),
        .busy_o    (busy_o),
        .timeout_o (timeout_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cycleNum++;

    always @(posedge clk) begin
        if (timeout_o) toCount++;
        if (overrun_o) ovCount++;
    end

    // LED controller model: reg0 output, reg1 toggle, reg2 clear; ack after ackDelay cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wbm.ack <= 1'b0;
            wbm.err <= 1'b0;
            waitCnt <= 0;
            ledReg = 4'h0;
        end else begin
            wbm.ack <= 1'b0;
            wbm.err <= 1'b0;
            if (wbm.cyc && wbm.stb && !wbm.ack && !wbm.err) begin
                if (ackDelay != 0 && waitCnt == ackDelay - 1) begin
                    waitCnt <= 0;
                    if (useErr != 0) begin
                        wbm.err <= 1'b1;
                    end else begin
                        wbm.ack <= 1'b1;
                        case (wbm.adr)
                            32'h0:   ledReg = wbm.dat[3:0];
                            32'h4:   ledReg = ledReg ^ wbm.dat[3:0];
                            32'h8:   ledReg = ledReg & ~wbm.dat[3:0];
                            default: ledReg = ledReg;
                        endcase
                        writeAdr.push_back(wbm.adr);
                        writeDat.push_back(wbm.dat);
                        ledLog.push_back(ledReg);
                        ackCycle.push_back(cycleNum);
                    end
                end else if (ackDelay != 0) begin
                    waitCnt <= waitCnt + 1;
                end
            end else begin
                waitCnt <= 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [23:0] period);
        @(negedge clk);
        modeIn   = mode;
        periodIn = period;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitStb(input logic level, input int budget, input string tag);
        int n = 0;
        while (wbm.stb !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (wbm.stb !== level) checkOutput(tag, 32'(wbm.stb), 32'(level));
    endtask

    task automatic waitWrites(input int target, input int budget, input string tag);
        int n = 0;
        while (writeAdr.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(writeAdr.size()), 32'(target));
    endtask

    initial begin
        int n;
        int base;
        int toBase;
        int ovBase;
        logic [31:0] adrOr;

        repeat (2) @(negedge clk);
        checkOutput("reset cyc/stb/we", 32'({wbm.cyc, wbm.stb, wbm.we}), 32'h0);
        checkOutput("reset sel", 32'(wbm.sel), 32'h0);
        checkOutput("reset adr", wbm.adr, 32'h0);
        checkOutput("reset dat", wbm.dat, 32'h0);
        checkOutput("reset busy/timeout/overrun", 32'({busy_o, timeout_o, overrun_o}), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] blink, period 9");
        applyStimulus(2'd1, 24'd9);
        n = 0;
        while (wbm.stb !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("blink first stb latency", 32'(n), 32'd11);
        checkOutput("blink busy", 32'(busy_o), 32'h1);
        checkOutput("blink adr", wbm.adr, 32'h4);
        checkOutput("blink dat", wbm.dat, 32'hF);
        checkOutput("blink sel", 32'(wbm.sel), 32'hF);
        waitWrites(3, 60, "blink write count");
        if (writeAdr.size() >= 3) begin
            checkOutput("blink led 1", 32'(ledLog[0]), 32'hF);
            checkOutput("blink led 2", 32'(ledLog[1]), 32'h0);
            checkOutput("blink led 3", 32'(ledLog[2]), 32'hF);
            checkOutput("blink interval 1", 32'(ackCycle[1] - ackCycle[0]), 32'd10);
            checkOutput("blink interval 2", 32'(ackCycle[2] - ackCycle[1]), 32'd10);
        end
        checkOutput("blink no timeout", 32'(toCount), 32'd0);

        applyStimulus(2'd0, 24'd9);
        repeat (3) @(negedge clk);
        base = writeAdr.size();
        repeat (30) @(negedge clk);
        checkOutput("mode0 no writes", 32'(writeAdr.size()), 32'(base));
        checkOutput("mode0 cyc idle", 32'(wbm.cyc), 32'h0);

        $display("[TB] chase, period 4");
        doReset();
        base = writeAdr.size();
        applyStimulus(2'd2, 24'd4);
        waitWrites(base + 5, 100, "chase write count");
        if (writeAdr.size() >= base + 5) begin
            checkOutput("chase dat 1", writeDat[base], 32'h1);
            checkOutput("chase dat 2", writeDat[base + 1], 32'h2);
            checkOutput("chase dat 3", writeDat[base + 2], 32'h4);
            checkOutput("chase dat 4", writeDat[base + 3], 32'h8);
            checkOutput("chase dat wrap", writeDat[base + 4], 32'h1);
            adrOr = 32'h0;
            for (int i = 0; i < 5; i++) adrOr = adrOr | writeAdr[base + i];
            checkOutput("chase adr", adrOr, 32'h0);
        end
        waitStb(1'b0, 10, "chase stb fall");
        checkOutput("chase gap busy", 32'(busy_o), 32'h0);

        $display("[TB] stalled slave, timeout then error");
        doReset();
        ackDelay = 0;
        applyStimulus(2'd2, 24'd40);
        waitStb(1'b1, 100, "timeout first stb");
        checkOutput("timeout first dat", wbm.dat, 32'h1);
        toBase = toCount;
        n = 0;
        while (wbm.stb === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout stb length", 32'(n), 32'd16);
        checkOutput("timeout pulse high", 32'(timeout_o), 32'h1);
        @(negedge clk);
        checkOutput("timeout pulse low", 32'(timeout_o), 32'h0);
        checkOutput("timeout pulse count", 32'(toCount - toBase), 32'd1);
        waitStb(1'b1, 100, "timeout retry stb");
        checkOutput("timeout retry dat", wbm.dat, 32'h1);
        useErr   = 1;
        ackDelay = 1;
        waitStb(1'b0, 10, "err stb fall");
        checkOutput("err pulse", 32'(timeout_o), 32'h1);
        useErr = 0;
        waitStb(1'b1, 100, "after err stb");
        checkOutput("after err dat", wbm.dat, 32'h1);
        waitStb(1'b0, 10, "after err stb fall");
        waitStb(1'b1, 100, "advance stb");
        checkOutput("advance dat", wbm.dat, 32'h2);

        $display("[TB] overrun with slow slave");
        applyStimulus(2'd0, 24'd40);
        repeat (10) @(negedge clk);
        ackDelay = 3;
        ovBase = ovCount;
        applyStimulus(2'd1, 24'd0);
        repeat (30) @(negedge clk);
        checkOutput("overrun seen", 32'(ovCount > ovBase), 32'h1);
        waitStb(1'b0, 10, "overrun stb fall");
        waitStb(1'b1, 10, "overrun stb rise");
        @(negedge clk);
        base = writeAdr.size();
        periodIn = 24'd1000;
        repeat (60) @(negedge clk);
        checkOutput("overrun single queued", 32'(writeAdr.size()), 32'(base + 2));

        $display("[TB] clear-once");
        ackDelay = 1;
        applyStimulus(2'd0, 24'd1000);
        repeat (20) @(negedge clk);
        base = writeAdr.size();
        applyStimulus(2'd3, 24'd1000);
        waitWrites(base + 1, 30, "clear write");
        if (writeAdr.size() >= base + 1) begin
            checkOutput("clear adr", writeAdr[base], 32'h8);
            checkOutput("clear dat", writeDat[base], 32'hF);
            checkOutput("clear led", 32'(ledLog[base]), 32'h0);
        end
        repeat (100) @(negedge clk);
        checkOutput("clear only once", 32'(writeAdr.size()), 32'(base + 1));
        applyStimulus(2'd1, 24'd1000);
        repeat (5) @(negedge clk);
        applyStimulus(2'd3, 24'd1000);
        repeat (100) @(negedge clk);
        checkOutput("clear re-entry", 32'(writeAdr.size()), 32'(base + 2));
        if (writeAdr.size() >= base + 2) checkOutput("clear re-entry adr", writeAdr[base + 1], 32'h8);

        $display("[TB] reset during a cycle");
        base = writeAdr.size();
        applyStimulus(2'd2, 24'd3);
        waitWrites(base + 3, 100, "pre-reset chase writes");
        waitStb(1'b0, 10, "pre-reset stb fall");
        ackDelay = 0;
        waitStb(1'b1, 50, "pre-reset stb rise");
        rst = 1'b1;
        #1;
        checkOutput("async reset cyc/stb", 32'({wbm.cyc, wbm.stb}), 32'h0);
        checkOutput("async reset busy", 32'(busy_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ackDelay = 1;
        waitStb(1'b1, 50, "post-reset stb");
        checkOutput("post-reset adr", wbm.adr, 32'h0);
        checkOutput("post-reset dat", wbm.dat, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
